// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM encoding, ACK/NACK levels, default target address.
package i2c_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 4;

    localparam logic [6:0] DEFAULT_TARGET_ADDR = 7'h68;

    // Bus levels of the acknowledge bit
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ADDR      = 4'd1,
        S_ADDR_ACK  = 4'd2,
        S_PTR       = 4'd3,
        S_PTR_ACK   = 4'd4,
        S_WDATA     = 4'd5,
        S_WDATA_ACK = 4'd6,
        S_RDATA     = 4'd7,
        S_RACK      = 4'd8,
        S_IGNORE    = 4'd9
    } i2c_state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA to clk_i and produces registered edge / START / STOP events.
module i2c_line_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic reset_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_now;
    logic                   sda_now;

    assign scl_now = scl_sync[SYNC_STAGES-1];
    assign sda_now = sda_sync[SYNC_STAGES-1];

    // Synchronizer chains (idle-high preset) and registered event detection
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync  <= '1;
            sda_sync  <= '1;
            scl_d     <= 1'b1;
            sda_d     <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            sda_s     <= 1'b1;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            scl_sync  <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync  <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_d     <= scl_now;
            sda_d     <= sda_now;
            scl_rise  <= scl_now & ~scl_d;
            scl_fall  <= ~scl_now & scl_d;
            sda_s     <= sda_now;
            start_det <= scl_now & scl_d & sda_d & ~sda_now;
            stop_det  <= scl_now & scl_d & ~sda_d & sda_now;
        end
    end

endmodule

// File: rtl/i2c_target.sv
// I2C target endpoint: address match, pointer write, burst write/read with auto-increment.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  TARGET_ADDR = DEFAULT_TARGET_ADDR,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        reset_n,
    input  logic        scl_i,
    inout  wire         sda_io,
    output logic [7:0]  reg_addr_o,
    output logic [7:0]  reg_wdata_o,
    output logic        reg_we_o,
    output logic        reg_re_o,
    input  logic [7:0]  reg_rdata_i,
    output logic        busy_o
);

    logic scl_rise, scl_fall, sda_s, start_det, stop_det;

    i2c_state_t          state, state_n;
    logic [CNT_W-1:0]    bit_cnt, bit_cnt_n;
    logic [BYTE_W-1:0]   shreg, shreg_n;
    logic [BYTE_W-1:0]   ptr_n, wdata_n;
    logic                we_n, re_n, busy_n;
    logic                drive, drive_n;
    logic                mack, mack_n;
    logic                sda_oe, sda_oe_n;

    i2c_line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_line_sync (
        .clk_i     (clk_i),
        .reset_n   (reset_n),
        .scl_i     (scl_i),
        .sda_i     (sda_io),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .sda_s     (sda_s),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    // Open-drain SDA: only ever pull low
    assign sda_io = sda_oe ? 1'b0 : 1'bz;

    // State and datapath registers
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            reg_addr_o  <= '0;
            reg_wdata_o <= '0;
            reg_we_o    <= 1'b0;
            reg_re_o    <= 1'b0;
            busy_o      <= 1'b0;
            drive       <= 1'b0;
            mack        <= NACK;
            sda_oe      <= 1'b0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            shreg       <= shreg_n;
            reg_addr_o  <= ptr_n;
            reg_wdata_o <= wdata_n;
            reg_we_o    <= we_n;
            reg_re_o    <= re_n;
            busy_o      <= busy_n;
            drive       <= drive_n;
            mack        <= mack_n;
            sda_oe      <= sda_oe_n;
        end
    end

    // Next-state and datapath logic; START/STOP override everything else
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        ptr_n     = reg_addr_o;
        wdata_n   = reg_wdata_o;
        we_n      = 1'b0;
        re_n      = 1'b0;
        busy_n    = busy_o;
        drive_n   = 1'b0;
        mack_n    = mack;
        sda_oe_n  = sda_oe;

        // Read pipeline: load the byte after the read strobe, then present its MSB
        if (reg_re_o) begin
            shreg_n = reg_rdata_i;
            drive_n = 1'b1;
        end
        if (drive) begin
            sda_oe_n = ~shreg[7];
        end

        case (state)
            S_ADDR, S_PTR, S_WDATA: begin
                if (scl_rise) begin
                    shreg_n   = {shreg[6:0], sda_s};
                    bit_cnt_n = bit_cnt + 4'd1;
                end else if (scl_fall && (bit_cnt == 4'd8)) begin
                    bit_cnt_n = '0;
                    if (state == S_ADDR) begin
                        if (shreg[7:1] == TARGET_ADDR) begin
                            state_n  = S_ADDR_ACK;
                            sda_oe_n = 1'b1;
                            busy_n   = 1'b1;
                        end else begin
                            state_n = S_IGNORE;
                        end
                    end else if (state == S_PTR) begin
                        ptr_n    = shreg;
                        sda_oe_n = 1'b1;
                        state_n  = S_PTR_ACK;
                    end else begin
                        we_n     = 1'b1;
                        wdata_n  = shreg;
                        sda_oe_n = 1'b1;
                        state_n  = S_WDATA_ACK;
                    end
                end
            end
            S_ADDR_ACK: begin
                if (scl_fall) begin
                    sda_oe_n  = 1'b0;
                    bit_cnt_n = '0;
                    if (shreg[0]) begin
                        re_n    = 1'b1;
                        state_n = S_RDATA;
                    end else begin
                        state_n = S_PTR;
                    end
                end
            end
            S_PTR_ACK: begin
                if (scl_fall) begin
                    sda_oe_n = 1'b0;
                    state_n  = S_WDATA;
                end
            end
            S_WDATA_ACK: begin
                if (scl_fall) begin
                    sda_oe_n = 1'b0;
                    ptr_n    = reg_addr_o + 8'd1;
                    state_n  = S_WDATA;
                end
            end
            S_RDATA: begin
                if (scl_fall) begin
                    if (bit_cnt == 4'd7) begin
                        sda_oe_n  = 1'b0;
                        bit_cnt_n = '0;
                        state_n   = S_RACK;
                    end else begin
                        bit_cnt_n = bit_cnt + 4'd1;
                        shreg_n   = {shreg[6:0], 1'b0};
                        sda_oe_n  = ~shreg[6];
                    end
                end
            end
            S_RACK: begin
                if (scl_rise) begin
                    mack_n = sda_s;
                end else if (scl_fall) begin
                    ptr_n     = reg_addr_o + 8'd1;
                    bit_cnt_n = '0;
                    if (mack == ACK) begin
                        re_n    = 1'b1;
                        state_n = S_RDATA;
                    end else begin
                        state_n = S_IGNORE;
                    end
                end
            end
            default: begin
            end
        endcase

        if (start_det) begin
            state_n   = S_ADDR;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
            we_n      = 1'b0;
            re_n      = 1'b0;
            drive_n   = 1'b0;
            ptr_n     = reg_addr_o;
        end else if (stop_det) begin
            state_n   = S_IDLE;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
            we_n      = 1'b0;
            re_n      = 1'b0;
            drive_n   = 1'b0;
            busy_n    = 1'b0;
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged bus master plus a small register-file model.
module tb_i2c_target;

    localparam int Q = 100;   // quarter SCL period in ns

    logic       clk;
    logic       reset_n;
    logic       scl;
    logic       m_sda_low;
    wire        sda_io;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       busy;

    logic [7:0] mem [256];
    logic [7:0] we_addr_q [$];
    logic [7:0] we_data_q [$];
    logic [7:0] re_addr_q [$];
    int         drove_cnt;

    int n_checks;
    int n_errors;

    assign sda_io = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda_io);
    assign reg_rdata = mem[reg_addr];

    i2c_target #(
        .TARGET_ADDR (7'h68),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i       (clk),
        .reset_n     (reset_n),
        .scl_i       (scl),
        .sda_io      (sda_io),
        .reg_addr_o  (reg_addr),
        .reg_wdata_o (reg_wdata),
        .reg_we_o    (reg_we),
        .reg_re_o    (reg_re),
        .reg_rdata_i (reg_rdata),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe recorder and target-drive detector
    initial drove_cnt = 0;
    always @(posedge clk) begin
        if (reg_we) begin
            we_addr_q.push_back(reg_addr);
            we_data_q.push_back(reg_wdata);
        end
        if (reg_re) re_addr_q.push_back(reg_addr);
        if (reset_n && sda_io === 1'b0 && !m_sda_low) drove_cnt <= drove_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_start();
        m_sda_low = 1'b0; #(Q);
        scl = 1'b1;       #(Q);
        m_sda_low = 1'b1; #(Q);
        scl = 1'b0;       #(Q);
    endtask

    task automatic bus_stop();
        m_sda_low = 1'b1; #(Q);
        scl = 1'b1;       #(Q);
        m_sda_low = 1'b0; #(Q);
    endtask

    task automatic clock_bit(input logic drv_low, output logic smp);
        m_sda_low = drv_low; #(Q);
        scl = 1'b1;          #(Q);
        smp = sda_io;        #(Q);
        scl = 1'b0;          #(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(~b[i], s);
        clock_bit(1'b0, s);
        acked = ~s;
    endtask

    task automatic read_byte(input logic give_ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b0, s);
            d[i] = s;
        end
        clock_bit(give_ack, s);
    endtask

    function automatic logic [31:0] qv(input logic [7:0] q [$], input int idx);
        return (idx < q.size()) ? 32'(q[idx]) : 32'hFFFF_FFFF;
    endfunction

    initial begin
        logic       ack;
        logic [7:0] d;
        logic       s;
        int         wb, rb, db;

        n_checks  = 0;
        n_errors  = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        mem[8'h3B] = 8'hA5;
        mem[8'h3C] = 8'h5A;
        mem[8'h10] = 8'h00;
        reset_n   = 1'b0;
        scl       = 1'b1;
        m_sda_low = 1'b0;
        #2;
        #50;
        check("rst_addr",  32'(reg_addr),  32'h0);
        check("rst_wdata", 32'(reg_wdata), 32'h0);
        check("rst_we",    32'(reg_we),    32'h0);
        check("rst_re",    32'(reg_re),    32'h0);
        check("rst_busy",  32'(busy),      32'h0);
        check("rst_sda",   32'(sda_io),    32'h1);
        reset_n = 1'b1;
        #100;

        // Basic write
        wb = we_addr_q.size();
        bus_start();
        write_byte(8'hD0, ack); check("t1_ack_addr", 32'(ack), 32'h1);
        check("t1_busy", 32'(busy), 32'h1);
        write_byte(8'h6B, ack); check("t1_ack_ptr", 32'(ack), 32'h1);
        write_byte(8'h00, ack); check("t1_ack_data", 32'(ack), 32'h1);
        bus_stop();
        #100;
        check("t1_we_cnt",  32'(we_addr_q.size() - wb), 32'd1);
        check("t1_we_addr", qv(we_addr_q, wb), 32'h6B);
        check("t1_we_data", qv(we_data_q, wb), 32'h00);
        check("t1_ptr",     32'(reg_addr), 32'h6C);
        check("t1_busy_end", 32'(busy), 32'h0);

        // Burst read with repeated START
        wb = we_addr_q.size();
        rb = re_addr_q.size();
        bus_start();
        write_byte(8'hD0, ack); check("t2_ack_w", 32'(ack), 32'h1);
        write_byte(8'h3B, ack); check("t2_ack_ptr", 32'(ack), 32'h1);
        bus_start();
        write_byte(8'hD1, ack); check("t2_ack_r", 32'(ack), 32'h1);
        read_byte(1'b1, d);     check("t2_byte0", 32'(d), 32'hA5);
        read_byte(1'b0, d);     check("t2_byte1", 32'(d), 32'h5A);
        #(Q);
        check("t2_sda_rel", 32'(sda_io), 32'h1);
        bus_stop();
        #100;
        check("t2_re_cnt",  32'(re_addr_q.size() - rb), 32'd2);
        check("t2_re_a0",   qv(re_addr_q, rb), 32'h3B);
        check("t2_re_a1",   qv(re_addr_q, rb + 1), 32'h3C);
        check("t2_ptr",     32'(reg_addr), 32'h3D);
        check("t2_we_cnt",  32'(we_addr_q.size() - wb), 32'd0);

        // Address mismatch
        wb = we_addr_q.size();
        rb = re_addr_q.size();
        db = drove_cnt;
        bus_start();
        write_byte(8'hA0, ack); check("t3_nack", 32'(ack), 32'h0);
        check("t3_busy", 32'(busy), 32'h0);
        write_byte(8'h12, ack);
        write_byte(8'h34, ack);
        bus_stop();
        #100;
        check("t3_drove", 32'(drove_cnt - db), 32'd0);
        check("t3_we_cnt", 32'(we_addr_q.size() - wb), 32'd0);
        check("t3_re_cnt", 32'(re_addr_q.size() - rb), 32'd0);

        // Pointer wrap
        wb = we_addr_q.size();
        bus_start();
        write_byte(8'hD0, ack);
        write_byte(8'hFF, ack);
        write_byte(8'h11, ack);
        write_byte(8'h22, ack); check("t4_ack_last", 32'(ack), 32'h1);
        bus_stop();
        #100;
        check("t4_we_cnt", 32'(we_addr_q.size() - wb), 32'd2);
        check("t4_a0", qv(we_addr_q, wb),     32'hFF);
        check("t4_d0", qv(we_data_q, wb),     32'h11);
        check("t4_a1", qv(we_addr_q, wb + 1), 32'h00);
        check("t4_d1", qv(we_data_q, wb + 1), 32'h22);
        check("t4_ptr", 32'(reg_addr), 32'h01);

        // Early STOP mid-byte, then a normal transfer
        wb = we_addr_q.size();
        bus_start();
        write_byte(8'hD0, ack);
        write_byte(8'h40, ack);
        clock_bit(1'b0, s); clock_bit(1'b1, s); clock_bit(1'b0, s); clock_bit(1'b1, s);
        bus_stop();
        #100;
        check("t5_we_none", 32'(we_addr_q.size() - wb), 32'd0);
        check("t5_busy",    32'(busy), 32'h0);
        bus_start();
        write_byte(8'hD0, ack); check("t5_ack_again", 32'(ack), 32'h1);
        write_byte(8'h41, ack);
        write_byte(8'h77, ack);
        bus_stop();
        #100;
        check("t5_we_cnt", 32'(we_addr_q.size() - wb), 32'd1);
        check("t5_a",      qv(we_addr_q, wb), 32'h41);
        check("t5_d",      qv(we_data_q, wb), 32'h77);

        // Reset while the target drives a 0 data bit
        bus_start();
        write_byte(8'hD0, ack);
        write_byte(8'h10, ack);
        bus_start();
        write_byte(8'hD1, ack); check("t6_ack_r", 32'(ack), 32'h1);
        #(Q);
        check("t6_sda_low", 32'(sda_io), 32'h0);
        reset_n = 1'b0;
        #1;
        check("t6_sda_rel",  32'(sda_io),  32'h1);
        check("t6_rst_addr", 32'(reg_addr), 32'h0);
        check("t6_rst_re",   32'(reg_re),   32'h0);
        check("t6_rst_busy", 32'(busy),     32'h0);
        #49;
        reset_n = 1'b1;
        #100;
        wb = we_addr_q.size();
        bus_start();
        write_byte(8'hD0, ack); check("t6_ack_after", 32'(ack), 32'h1);
        write_byte(8'h05, ack);
        write_byte(8'h99, ack);
        bus_stop();
        #100;
        check("t6_we_cnt", 32'(we_addr_q.size() - wb), 32'd1);
        check("t6_a",      qv(we_addr_q, wb), 32'h05);
        check("t6_d",      qv(we_data_q, wb), 32'h99);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
# i2c_target

I2C target (slave) endpoint that answers the bus-master traffic our sequencer produces: 7-bit address match, register-pointer write, multi-byte writes and reads with auto-increment, repeated START. It oversamples SCL/SDA on the system clock, drives SDA open-drain, and exposes a simple synchronous register-file port. It is used as a loop-back target for the master sequencer, mimicking an MPU-6050 at 0xD0/0xD1, and as a board-level peripheral.

## Interface
- `TARGET_ADDR`, default 7'h68, 7-bit bus address; 0xD0 is write and 0xD1 is read.
- `SYNC_STAGES`, default 2, number of synchronizer flops on `scl_i`/`sda_io` (≥2).
- `clk_i` in 1: system clock; must be ≥ 10× the SCL frequency.
- `reset_n` in 1: asynchronous, active-low reset.
- `scl_i` in 1: bus clock. Input only; the block never stretches the clock.
- `sda_io` inout 1: open-drain. Driven to 0 when `sda_oe` is set, else `z`.
- `reg_addr_o` out 8: current register pointer.
- `reg_wdata_o` out 8: write data, valid while `reg_we_o` is high.
- `reg_we_o` out 1: one-cycle write strobe.
- `reg_re_o` out 1: one-cycle read strobe. `reg_rdata_i` is sampled on the next `clk_i` edge.
- `reg_rdata_i` in 8: read data from the register file.
- `busy_o` out 1: high from an address-matched START until STOP.

## Operation
- **Line conditioning**
  - SCL/SDA are synchronized, then edge-detected.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Data is sampled on the detected SCL rise.
- **States:** IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE.
- **START or repeated START from any state:** go to ADDR, bit counter = 0. The register pointer is retained.
- **STOP from any state:** go to IDLE, release SDA, `busy_o` = 0. No strobe is issued for a partial byte.
- **ADDR:** shift in 8 bits, MSB first.
  - Bits[7:1] == `TARGET_ADDR`: go to ADDR_ACK and drive ACK.
  - Otherwise: go to IGNORE. No ACK, no strobes until START or STOP.
- **ADDR_ACK**
  - R/W = 0: go to PTR.
  - R/W = 1: pulse `reg_re_o` at the pointer, load the shift register, go to RDATA.
- **PTR:** the first byte after a write address is loaded into the pointer. ACK, then go to WDATA.
- **WDATA:** on the 8th bit:
  - pulse `reg_we_o` with `reg_addr_o` = pointer and `reg_wdata_o` = byte;
  - ACK, then pointer++.
- **RDATA:** shift the byte out MSB first, then go to RACK.
- **RACK:** sample the master's ACK.
  - ACK (0): pointer++, pulse `reg_re_o`, reload, go to RDATA.
  - NACK (1): pointer++, release SDA, go to IGNORE until STOP or START.
- **Pointer arithmetic:** 8-bit, wraps 0xFF → 0x00.

## Timing
- Pin-to-event latency is `SYNC_STAGES` + 1 `clk_i` cycles.
- SDA changes only after a detected SCL fall, one `clk_i` later, so it never changes while SCL is high.
- ACK is driven from the SCL fall after bit 8 until the SCL fall after the 9th clock.
- `reg_we_o` is asserted on the same `clk_i` cycle the ACK drive begins.
- `reg_re_o` fires on the SCL fall that ends the address ACK or the master ACK. The shift register loads `reg_rdata_i` on the next cycle, and the MSB is driven on the cycle after that, still inside SCL low.
- START/STOP take priority over a coincident SCL edge.
- **Reset values:**
  - `sda_oe` = 0 (SDA released immediately, asynchronously).
  - `reg_addr_o` = 0, `reg_wdata_o` = 0.
  - `reg_we_o` = 0, `reg_re_o` = 0, `busy_o` = 0.
  - State = IDLE; synchronizers preset to 1.
- Reset mid-byte leaves no partial strobe. The first transaction after reset needs a fresh START.

## Structure
- **Shared package `i2c_pkg`:** state encoding localparams, the ACK/NACK constants, and the default target address 7'h68, shared with the master sequencer.
- **Sub-module `i2c_line_sync`:** synchronizers and edge detectors for both lines. Outputs `scl_rise`, `scl_fall`, `sda_s`, `start_det` and `stop_det`.
- **Top:** holds the FSM, bit counter, shift register and pointer.

## Test plan
1. **Basic write:** master writes D0, 6B, 00, then STOP. Expect ACK on all three bytes and exactly one `reg_we_o` with addr 0x6B, data 0x00. `busy_o` falls after STOP.
2. **Burst read with repeated START:** master sends D0, 3B, Sr, D1, then reads 2 bytes (ACK, then NACK); the model returns 0xA5 @0x3B and 0x5A @0x3C. Expect bytes A5, 5A on the bus, `reg_re_o` at 0x3B and 0x3C, pointer ends at 0x3D, SDA released after the NACK.
3. **Address mismatch:** master sends A0, 12, 34. Expect SDA never driven, no strobes, `busy_o` = 0.
4. **Pointer wrap:** master sends D0, FF, 11, 22. Expect writes 0xFF ← 0x11 and 0x00 ← 0x22.
5. **Early STOP:** STOP after 4 bits of a data byte. Expect no `reg_we_o`, state IDLE; a following transfer works normally.
6. **Reset mid-read:** assert `reset_n` = 0 while driving a 0 data bit. Expect SDA to go to z in the same delta, all outputs at their reset values, and the next START accepted.
